// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared address constants and bus encodings for the I/O port bank
package io_pkg;

    // Control register addresses (5-bit map; channel registers occupy 0..N_ANA+N_DIG-1)
    localparam logic [4:0] ADDR_DIR_D = 5'h18;
    localparam logic [4:0] ADDR_DIR_A = 5'h19;
    localparam logic [4:0] ADDR_EDGE  = 5'h1A;
    localparam logic [4:0] ADDR_MASK  = 5'h1B;

    // r_or_w encoding
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/io_debounce.sv
// rtl/io_debounce.sv - digital input synchroniser, debounce counter and rising-edge detect
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   pin_in   in   raw asynchronous pin level
//   restart  in   hold the filter: counter cleared, level frozen, no rise
//   level    out  debounced level
//   rise     out  combinational pulse, high in the cycle the level goes 0->1
module io_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_in,
    input  logic restart,
    output logic level,
    output logic rise
);
    import io_pkg::*;

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter tracks consecutive samples that disagree with the accepted level;
    // the DEBOUNCE-th such sample flips the level. Any agreeing sample restarts it.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (sync2_q != level_q) begin
            if (cnt_q == LAST) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pin_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = ~level_q & level_d;

endmodule

// File: rtl/io_port_bank.sv
// rtl/io_port_bank.sv - parametrised PLC I/O bank: analog/digital channels, direction, debounce, edge irq
//
// Ports:
//   clk       in     system clock
//   rst       in     synchronous active-high reset
//   en        in     bus access strobe
//   r_or_w    in     1 = write, 0 = read
//   io_addr   in     register address
//   data_in   in     write data
//   data_out  out    read data, zero unless rd_valid
//   rd_valid  out    one-cycle read-data pulse, one cycle after the read strobe
//   irq       out    registered OR of unmasked rising-edge flags
//   a_io      inout  analog pins, channel i at [i*BITS +: BITS]
//   d_io      inout  digital pins
module io_port_bank #(
    parameter int BITS     = 16,
    parameter int N_ANA    = 2,
    parameter int N_DIG    = 8,
    parameter int DEBOUNCE = 4,
    parameter int ADDR_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  r_or_w,
    input  logic [ADDR_W-1:0]     io_addr,
    input  logic [BITS-1:0]       data_in,
    output logic [BITS-1:0]       data_out,
    output logic                  rd_valid,
    output logic                  irq,
    inout  wire  [N_ANA*BITS-1:0] a_io,
    inout  wire  [N_DIG-1:0]      d_io
);
    import io_pkg::*;

    logic [BITS-1:0]  ana_out_q [N_ANA];
    logic [BITS-1:0]  ana_out_d [N_ANA];
    logic [N_DIG-1:0] dig_out_q, dig_out_d;
    logic [N_DIG-1:0] dir_d_q, dir_d_d;
    logic [N_ANA-1:0] dir_a_q, dir_a_d;
    logic [N_DIG-1:0] edge_q, edge_d;
    logic [N_DIG-1:0] mask_q, mask_d;
    logic [BITS-1:0]  data_out_q, data_out_d;
    logic             rd_valid_q, rd_valid_d;
    logic             irq_q, irq_d;

    logic [N_DIG-1:0] level;
    logic [N_DIG-1:0] rise;
    logic [N_DIG-1:0] w1c;
    logic [BITS-1:0]  rd_word;
    logic             wr, rd;

    assign wr = en & (r_or_w == RW_WRITE);
    assign rd = en & (r_or_w == RW_READ);

    // Output channels keep their filter frozen so a later switch back to input
    // resumes from the last accepted level instead of the driven pin value.
    for (genvar j = 0; j < N_DIG; j++) begin : g_dig
        io_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
            .clk     (clk),
            .rst     (rst),
            .pin_in  (d_io[j]),
            .restart (dir_d_q[j]),
            .level   (level[j]),
            .rise    (rise[j])
        );
        assign d_io[j] = dir_d_q[j] ? dig_out_q[j] : 1'bz;
    end

    for (genvar i = 0; i < N_ANA; i++) begin : g_ana
        assign a_io[i*BITS +: BITS] = dir_a_q[i] ? ana_out_q[i] : {BITS{1'bz}};
    end

    always_comb begin
        ana_out_d = ana_out_q;
        dig_out_d = dig_out_q;
        dir_d_d   = dir_d_q;
        dir_a_d   = dir_a_q;
        mask_d    = mask_q;
        w1c       = '0;
        if (wr) begin
            for (int i = 0; i < N_ANA; i++) begin
                if (io_addr == ADDR_W'(i)) ana_out_d[i] = data_in;
            end
            for (int j = 0; j < N_DIG; j++) begin
                if (io_addr == ADDR_W'(N_ANA + j)) dig_out_d[j] = data_in[0];
            end
            if (io_addr == ADDR_W'(ADDR_DIR_D)) dir_d_d = data_in[N_DIG-1:0];
            if (io_addr == ADDR_W'(ADDR_DIR_A)) dir_a_d = data_in[N_ANA-1:0];
            if (io_addr == ADDR_W'(ADDR_EDGE))  w1c     = data_in[N_DIG-1:0];
            if (io_addr == ADDR_W'(ADDR_MASK))  mask_d  = data_in[N_DIG-1:0];
        end
        // Set is ORed in after the clear so a same-cycle edge survives W1C.
        edge_d = (edge_q & ~w1c) | (rise & ~dir_d_q);
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < N_ANA; i++) begin
            if (io_addr == ADDR_W'(i))
                rd_word = dir_a_q[i] ? ana_out_q[i] : a_io[i*BITS +: BITS];
        end
        for (int j = 0; j < N_DIG; j++) begin
            if (io_addr == ADDR_W'(N_ANA + j))
                rd_word = BITS'(dir_d_q[j] ? dig_out_q[j] : level[j]);
        end
        if (io_addr == ADDR_W'(ADDR_DIR_D)) rd_word = BITS'(dir_d_q);
        if (io_addr == ADDR_W'(ADDR_DIR_A)) rd_word = BITS'(dir_a_q);
        if (io_addr == ADDR_W'(ADDR_EDGE))  rd_word = BITS'(edge_q);
        if (io_addr == ADDR_W'(ADDR_MASK))  rd_word = BITS'(mask_q);

        data_out_d = rd ? rd_word : '0;
        rd_valid_d = rd;
        irq_d      = |(edge_q & mask_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ANA; i++) ana_out_q[i] <= '0;
            dig_out_q  <= '0;
            dir_d_q    <= '0;
            dir_a_q    <= '0;
            edge_q     <= '0;
            mask_q     <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ana_out_q  <= ana_out_d;
            dig_out_q  <= dig_out_d;
            dir_d_q    <= dir_d_d;
            dir_a_q    <= dir_a_d;
            edge_q     <= edge_d;
            mask_q     <= mask_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            irq_q      <= irq_d;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_io_port_bank.sv
// tb/tb_io_port_bank.sv - directed self-checking bench for io_port_bank
module tb_io_port_bank;

    localparam int BITS     = 16;
    localparam int N_ANA    = 2;
    localparam int N_DIG    = 8;
    localparam int DEBOUNCE = 4;
    localparam int ADDR_W   = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        r_or_w;
    logic [4:0]  io_addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        rd_valid;
    logic        irq;
    wire  [31:0] a_io;
    wire  [7:0]  d_io;

    logic [31:0] a_drv;
    logic [1:0]  a_en;
    logic [7:0]  d_drv;
    logic [7:0]  d_en;

    int checks = 0;
    int errors = 0;

    logic [15:0] rdat;
    logic        rval;
    logic [4:0]  addrs [16];

    always #5 clk = ~clk;

    assign a_io[15:0]  = a_en[0] ? a_drv[15:0]  : 16'bz;
    assign a_io[31:16] = a_en[1] ? a_drv[31:16] : 16'bz;
    for (genvar k = 0; k < 8; k++) begin : g_dpin
        assign d_io[k] = d_en[k] ? d_drv[k] : 1'bz;
    end

    io_port_bank #(
        .BITS(BITS), .N_ANA(N_ANA), .N_DIG(N_DIG), .DEBOUNCE(DEBOUNCE), .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .r_or_w   (r_or_w),
        .io_addr  (io_addr),
        .data_in  (data_in),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .irq      (irq),
        .a_io     (a_io),
        .d_io     (d_io)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [4:0] a, output logic [15:0] d, output logic v);
        @(negedge clk);
        en = 1'b1; r_or_w = 1'b0; io_addr = a;
        @(posedge clk);
        #1;
        d = data_out;
        v = rd_valid;
        en = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [15:0] d);
        @(negedge clk);
        en = 1'b1; r_or_w = 1'b1; io_addr = a; data_in = d;
        @(posedge clk);
        #1;
        en = 1'b0; r_or_w = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; r_or_w = 1'b0; io_addr = '0; data_in = '0;
        a_en = 2'b11; a_drv = 32'h5A5A_C3C3;
        d_en = 8'hFF; d_drv = 8'hA5;

        // 1: reset state, pins released, every address reads 0 with latency 1
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_valid", rd_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_irq", irq, 0);
        check("rst_d_io_released", d_io, 32'hA5);
        check("rst_a_io_released", a_io, 32'h5A5A_C3C3);
        d_drv = 8'h00; a_drv = 32'h0;
        repeat (4) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        addrs = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                  5'h18, 5'h19, 5'h1A, 5'h1B, 5'h0A, 5'h1F};
        for (int i = 0; i < 16; i++) begin
            do_read(addrs[i], rdat, rval);
            check($sformatf("init_rd_valid_%0h", addrs[i]), rval, 1);
            check($sformatf("init_rd_data_%0h", addrs[i]), rdat, 0);
        end
        @(posedge clk);
        #1;
        check("idle_rd_valid", rd_valid, 0);
        check("idle_data_out", data_out, 0);
        check("init_irq", irq, 0);

        // 2: digital output channel 0
        d_en = 8'hFE;
        do_write(5'h18, 16'h0001);
        do_write(5'd2, 16'h0001);
        check("dig0_pin", d_io[0], 1);
        do_read(5'd2, rdat, rval);
        check("dig0_read", rdat, 16'h0001);
        do_read(5'h18, rdat, rval);
        check("dir_d_read", rdat, 16'h0001);

        // 3: debounced rising edge on channel 1, flag, mask, irq, W1C
        @(negedge clk) d_drv[1] = 1'b1;
        repeat (5) @(posedge clk);
        do_read(5'd3, rdat, rval);
        check("dig1_before_latency", rdat, 0);
        do_read(5'd3, rdat, rval);
        check("dig1_after_latency", rdat, 16'h0001);
        do_read(5'h1A, rdat, rval);
        check("edge_bit1", rdat, 16'h0002);
        check("irq_masked", irq, 0);
        do_write(5'h1B, 16'h0002);
        check("irq_mask_same_cycle", irq, 0);
        @(posedge clk);
        #1;
        check("irq_after_mask", irq, 1);
        do_write(5'h1A, 16'h0002);
        check("irq_w1c_same_cycle", irq, 1);
        @(posedge clk);
        #1;
        check("irq_after_w1c", irq, 0);
        do_read(5'h1A, rdat, rval);
        check("edge_after_w1c", rdat, 0);

        // 4: 3-cycle glitch is filtered
        @(negedge clk) d_drv[2] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) d_drv[2] = 1'b0;
        repeat (10) @(posedge clk);
        do_read(5'd4, rdat, rval);
        check("glitch_level", rdat, 0);
        do_read(5'h1A, rdat, rval);
        check("glitch_edge", rdat, 0);

        // 5: W1C in the cycle the flag is set -> set wins
        @(negedge clk) d_drv[3] = 1'b1;
        repeat (5) @(posedge clk);
        do_write(5'h1A, 16'h0008);
        do_read(5'h1A, rdat, rval);
        check("edge_set_wins", rdat, 16'h0008);
        do_read(5'd5, rdat, rval);
        check("dig3_level", rdat, 16'h0001);
        check("irq_unmasked_bit3", irq, 0);
        do_write(5'h1A, 16'h0008);
        do_read(5'h1A, rdat, rval);
        check("edge_bit3_cleared", rdat, 0);

        // 6: analog output/input, reset mid-read
        a_en = 2'b10; a_drv[31:16] = 16'h1234;
        do_write(5'h19, 16'h0001);
        do_write(5'd0, 16'hBEEF);
        check("ana0_pin", a_io[15:0], 16'hBEEF);
        do_read(5'd0, rdat, rval);
        check("ana0_read_latch", rdat, 16'hBEEF);
        do_read(5'd1, rdat, rval);
        check("ana1_read_pin", rdat, 16'h1234);
        @(negedge clk);
        en = 1'b1; r_or_w = 1'b0; io_addr = 5'd0; rst = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        check("rst_mid_read_valid", rd_valid, 0);
        check("rst_mid_read_data", data_out, 0);
        @(posedge clk);
        #1;
        check("rst_mid_read_no_late_valid", rd_valid, 0);
        a_en[0] = 1'b1; a_drv[15:0] = 16'h1357;
        #1;
        check("ana0_released", a_io[15:0], 16'h1357);
        @(negedge clk) rst = 1'b0;
        do_read(5'h19, rdat, rval);
        check("dir_a_after_rst", rdat, 0);
        check("dir_a_after_rst_valid", rval, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
